lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci LFSR for the pseudo-random stimulus and test-pattern path. It generalises the fixed 4-bit seed-loadable shift register to any width and tap mask, and adds three things the fixed version lacks: all-zero seed lock-up protection, a counted burst mode with a busy/done handshake, and on-line period measurement.

## Interface
- WIDTH, 4: register width, ≥ 2.
- TAPS, 4'b1001: feedback mask, WIDTH bits; bit i set means state[i] feeds the XOR. TAPS[WIDTH-1] must be 1 (elaboration-time check).
- SEED_RST, 4'b0001: state after reset; must be non-zero.
- CW, 8: width of burst_len.
- clkslow in 1: the single clock; all logic is on its rising edge.
- rst in 1: synchronous, active-high reset.
- load in 1: load seed this cycle.
- seed in WIDTH: value to load.
- en in 1: free-run stepping, one step per cycle while high.
- burst_start in 1: start a counted burst.
- burst_len in CW: number of steps in the burst.
- state out WIDTH: current register value.
- bit_out out 1: state[WIDTH-1].
- busy out 1: high while a burst is in progress.
- done out 1: one-cycle pulse when a burst completes.
- wrap out 1: one-cycle pulse when state returns to the reference seed.
- period out WIDTH: last measured cycle length in steps.
- period_valid out 1: period holds a measurement.
- seed_fixed out 1: the last load had an all-zero seed that was substituted.

## Operation
- Step: state <= {state[WIDTH-2:0], fb}, where fb = XOR of (state & TAPS).
- FSM states are IDLE, FREE and BURST.
  - IDLE → FREE when en=1.
  - IDLE or FREE → BURST when burst_start=1 and burst_len≠0.
  - FREE → IDLE when en=0.
  - BURST → IDLE after the last step.
  - en is ignored while in BURST.
- Priority: rst > load > burst_start > en.
- load:
  - state <= seed, or SEED_RST if seed==0; seed_fixed follows the substitution.
  - The loaded value becomes the reference seed.
  - Step counter clears; period_valid clears.
  - Any burst aborts: FSM → IDLE, busy=0, no done pulse.
- burst_start with burst_len=0: no step, no state change. done pulses the next cycle; busy stays 0.
- burst_start while busy: ignored.
- Burst of N: exactly N steps on N consecutive cycles.
- Period measurement:
  - A WIDTH-bit step counter increments on every step.
  - When a step produces state==reference seed: period <= counter+1, period_valid <= 1, wrap pulses, counter <= 0.
  - Measurement continues on later wraps.

## Timing
- Reset values: state=SEED_RST, reference seed=SEED_RST, period=0, period_valid=0, busy=0, done=0, wrap=0, seed_fixed=0, FSM=IDLE.
- load takes effect on the next edge; state shows the seed the following cycle.
- burst_start sampled at edge k:
  - busy=1 from k+1.
  - Steps occur on edges k+1 … k+N.
  - At edge k+N: busy→0 and done=1 for one cycle.
  - done is coincident with the final state.
- wrap, period and period_valid update on the same edge as the wrapping step, so they are visible alongside the wrapped state.
- rst mid-burst: everything returns to reset values; no done pulse.
- load and burst_start in the same cycle: load wins and the burst is dropped.

## Structure
- Shared package lfsr_pkg holds the FSM state enum (IDLE/FREE/BURST) and a function lfsr_next(state, taps). The stimulus generators reuse both.
- A sub-module lfsr_period_mon (step counter, reference-seed compare, wrap/period registers) is natural. The core keeps the FSM and the shift register.

## Test plan
- Reset: rst=1 for 1 cycle → state=0001, busy=0, period_valid=0.
- Free-run, WIDTH=4, TAPS=1001, load seed 0001, en=1 → state sequence 0011, 0111, 1111, 1110, …; after 15 steps wrap=1, period=15, period_valid=1.
- Zero seed: load seed=0000 → state=0001, seed_fixed=1.
- Burst: load 0001, then burst_start with burst_len=3 → busy high for 3 cycles; final state 1111 with a one-cycle done in that cycle.
- burst_len=0 → done pulses once, busy never rises, state unchanged.
- Abort: load 1000 during a 10-step burst after step 2 → busy=0, no done, state=1000, period_valid=0; en=1 then gives next state 0001.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM state encoding and the generic Fibonacci step.
// Used by the generator core and by the stimulus generators.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    FREE,
    BURST
  } lfsr_fsm_t;

  // Callers zero-extend into LFSR_MAX_W and truncate the result back to their width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] cur,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {cur[LFSR_MAX_W-2:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Period monitor: counts LFSR steps and records the cycle length each time
// the register returns to the reference seed.
module lfsr_period_mon #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] SEED_RST = 4'b0001
) (
  input  logic             clkslow,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] clear_val,
  input  logic             step,
  input  logic [WIDTH-1:0] next_state,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  logic             wrap_q;

  always_ff @(posedge clkslow) begin
    if (rst) begin
      ref_q    <= SEED_RST;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear) begin
        ref_q   <= clear_val;
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else if (step) begin
        // Compare against the post-step value so the wrap flags line up with the wrapped state.
        if (next_state == ref_q) begin
          period_q <= cnt_q + WIDTH'(1);
          valid_q  <= 1'b1;
          wrap_q   <= 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
      end
    end
  end

  assign wrap         = wrap_q;
  assign period       = period_q;
  assign period_valid = valid_q;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, zero-seed protection,
// counted bursts with busy/done handshake, and on-line period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
  parameter logic [WIDTH-1:0] SEED_RST = 4'b0001,
  parameter int unsigned      CW       = 8
) (
  input  logic             clkslow,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             burst_start,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             seed_fixed
);

  if (WIDTH < 2 || WIDTH > LFSR_MAX_W) begin : g_chk_width
    $error("lfsr_gen: WIDTH out of range");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_chk_taps
    $error("lfsr_gen: TAPS MSB must be set");
  end
  if (SEED_RST == '0) begin : g_chk_seed
    $error("lfsr_gen: SEED_RST must be non-zero");
  end

  lfsr_fsm_t        fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;
  logic             fixed_q, fixed_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             step;

  assign step_val = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS)));
  assign load_val = (seed == '0) ? SEED_RST : seed;

  always_ff @(posedge clkslow) begin
    if (rst) begin
      fsm_q   <= IDLE;
      lfsr_q  <= SEED_RST;
      rem_q   <= '0;
      done_q  <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      fixed_q <= fixed_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    fixed_d = fixed_q;
    step    = 1'b0;
    if (load) begin
      lfsr_d  = load_val;
      fixed_d = (seed == '0);
      fsm_d   = IDLE;
      rem_d   = '0;
    end else begin
      unique case (fsm_q)
        BURST: begin
          step   = 1'b1;
          lfsr_d = step_val;
          rem_d  = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
        default: begin
          // A zero-length burst only acknowledges; it neither steps nor changes mode.
          if (burst_start) begin
            if (burst_len != '0) begin
              fsm_d = BURST;
              rem_d = burst_len;
            end else begin
              done_d = 1'b1;
            end
          end else if (en) begin
            step   = 1'b1;
            lfsr_d = step_val;
            fsm_d  = FREE;
          end else begin
            fsm_d = IDLE;
          end
        end
      endcase
    end
  end

  lfsr_period_mon #(
    .WIDTH    (WIDTH),
    .SEED_RST (SEED_RST)
  ) u_period_mon (
    .clkslow      (clkslow),
    .rst          (rst),
    .clear        (load),
    .clear_val    (load_val),
    .step         (step),
    .next_state   (step_val),
    .wrap         (wrap),
    .period       (period),
    .period_valid (period_valid)
  );

  assign state      = lfsr_q;
  assign bit_out    = lfsr_q[WIDTH-1];
  assign busy       = (fsm_q == BURST);
  assign done       = done_q;
  assign seed_fixed = fixed_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a behavioural model queues the expected
// outputs for each driven cycle, which are compared just after the edge.
module tb_lfsr_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam logic [W-1:0] TP = 4'b1001;
  localparam logic [W-1:0] SR = 4'b0001;

  logic          clkslow = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  seed = '0;
  logic          en = 1'b0;
  logic          burst_start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic [W-1:0]  state;
  logic          bit_out;
  logic          busy;
  logic          done;
  logic          wrap;
  logic [W-1:0]  period;
  logic          period_valid;
  logic          seed_fixed;

  always #5 clkslow = ~clkslow;

  lfsr_gen #(
    .WIDTH    (W),
    .TAPS     (TP),
    .SEED_RST (SR),
    .CW       (CW)
  ) dut (
    .clkslow      (clkslow),
    .rst          (rst),
    .load         (load),
    .seed         (seed),
    .en           (en),
    .burst_start  (burst_start),
    .burst_len    (burst_len),
    .state        (state),
    .bit_out      (bit_out),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap),
    .period       (period),
    .period_valid (period_valid),
    .seed_fixed   (seed_fixed)
  );

  typedef struct {
    logic [W-1:0] st;
    logic         busy;
    logic         done;
    logic         wrap;
    logic [W-1:0] period;
    logic         pv;
    logic         fixed;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0]  m_state, m_ref, m_cnt, m_period;
  logic          m_pv, m_busy, m_done, m_wrap, m_fixed;
  logic [CW-1:0] m_rem;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mnext(input logic [W-1:0] s);
    logic [W-1:0] t;
    logic fb;
    t = TP;
    fb = 1'b0;
    for (int i = 0; i < W; i++)
      if (t[i]) fb = fb ^ s[i];
    return {s[W-2:0], fb};
  endfunction

  task automatic m_do_step();
    m_state = mnext(m_state);
    if (m_state == m_ref) begin
      m_period = m_cnt + 4'd1;
      m_pv     = 1'b1;
      m_wrap   = 1'b1;
      m_cnt    = '0;
    end else begin
      m_cnt = m_cnt + 4'd1;
    end
  endtask

  task automatic model(input logic r, input logic ld, input logic [W-1:0] sd,
                       input logic e, input logic bs, input logic [CW-1:0] bl);
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (r) begin
      m_state = SR; m_ref = SR; m_cnt = '0; m_period = '0; m_pv = 1'b0;
      m_busy = 1'b0; m_rem = '0; m_fixed = 1'b0;
    end else if (ld) begin
      m_fixed = (sd == '0);
      m_state = m_fixed ? SR : sd;
      m_ref   = m_state;
      m_cnt   = '0;
      m_pv    = 1'b0;
      m_busy  = 1'b0;
    end else if (m_busy) begin
      m_do_step();
      m_rem = m_rem - 8'd1;
      if (m_rem == '0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (bs) begin
      if (bl != '0) begin
        m_busy = 1'b1;
        m_rem  = bl;
      end else begin
        m_done = 1'b1;
      end
    end else if (e) begin
      m_do_step();
    end
  endtask

  task automatic cycle(input logic r, input logic ld, input logic [W-1:0] sd,
                       input logic e, input logic bs, input logic [CW-1:0] bl);
    exp_t x;
    rst = r; load = ld; seed = sd; en = e; burst_start = bs; burst_len = bl;
    model(r, ld, sd, e, bs, bl);
    x.st = m_state; x.busy = m_busy; x.done = m_done; x.wrap = m_wrap;
    x.period = m_period; x.pv = m_pv; x.fixed = m_fixed;
    sb.push_back(x);
    @(posedge clkslow);
    #1;
    x = sb.pop_front();
    check("state",        32'(state),        32'(x.st));
    check("bit_out",      32'(bit_out),      32'(x.st[W-1]));
    check("busy",         32'(busy),         32'(x.busy));
    check("done",         32'(done),         32'(x.done));
    check("wrap",         32'(wrap),         32'(x.wrap));
    check("period",       32'(period),       32'(x.period));
    check("period_valid", 32'(period_valid), 32'(x.pv));
    check("seed_fixed",   32'(seed_fixed),   32'(x.fixed));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [W-1:0] seq[4];
    seq[0] = 4'b0011; seq[1] = 4'b0111; seq[2] = 4'b1111; seq[3] = 4'b1110;

    // reset
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check("rst_state", 32'(state), 32'h1);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_pv",    32'(period_valid), 32'h0);

    // free-run from 0001, full period and a second wrap
    cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
      if (i < 4) check("free_seq", 32'(state), 32'(seq[i]));
    end
    check("wrap15",   32'(wrap),         32'h1);
    check("period15", 32'(period),       32'd15);
    check("pv15",     32'(period_valid), 32'h1);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle(1);

    // zero seed substitution
    cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, '0);
    check("zero_state", 32'(state),      32'h1);
    check("zero_fixed", 32'(seed_fixed), 32'h1);

    // burst of 3
    cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'd3);
    check("burst_busy0", 32'(busy), 32'h1);
    idle(2);
    check("burst_busy2", 32'(busy), 32'h1);
    idle(1);
    check("burst_final", 32'(state), 32'hF);
    check("burst_done",  32'(done),  32'h1);
    check("burst_idle",  32'(busy),  32'h0);
    idle(1);

    // zero-length burst
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'd0);
    check("len0_done",  32'(done),  32'h1);
    check("len0_busy",  32'(busy),  32'h0);
    check("len0_state", 32'(state), 32'hF);
    idle(2);

    // burst_start and en while busy are ignored
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'd5);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'd2);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle(4);

    // abort by load after 2 steps
    cycle(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'd10);
    idle(2);
    cycle(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, '0);
    check("abort_busy",  32'(busy),         32'h0);
    check("abort_done",  32'(done),         32'h0);
    check("abort_state", 32'(state),        32'h8);
    check("abort_pv",    32'(period_valid), 32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("abort_next",  32'(state),        32'h1);
    idle(12);

    // reset mid-burst
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'd6);
    idle(2);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check("rstmid_state", 32'(state), 32'h1);
    check("rstmid_busy",  32'(busy),  32'h0);
    idle(8);

    // load and burst_start together: load wins
    cycle(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 8'd4);
    check("ldbs_busy",  32'(busy),  32'h0);
    check("ldbs_state", 32'(state), 32'h5);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
            CW'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
